// File: rtl/hex_glyph_pkg.sv
// Shared constants for the seven-segment "HELLO" loop-back decoder:
// glyph codes, segment patterns (bit i = segment a+i, active-low), message ring, FSM states.
package hex_glyph_pkg;

  typedef enum logic [2:0] {
    BLANK = 3'd0,
    H     = 3'd1,
    E     = 3'd2,
    L     = 3'd3,
    O     = 3'd4,
    BAD   = 3'd7
  } glyph_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_O     = 7'b1000000;

  // Rotation r shows W[(k-r) mod 8] on digit k.
  localparam glyph_t W [8] = '{O, L, L, E, H, BLANK, BLANK, BLANK};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    MATCH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/glyph_decode.sv
// Combinational segment-pattern to glyph-code decoder; anything unrecognised is BAD.
module glyph_decode
  import hex_glyph_pkg::*;
(
  input  logic [6:0] seg,
  output logic [2:0] code
);

  always_comb begin
    code = BAD;
    case (seg)
      SEG_BLANK: code = BLANK;
      SEG_H:     code = H;
      SEG_E:     code = E;
      SEG_L:     code = L;
      SEG_O:     code = O;
      default:   code = BAD;
    endcase
  end

endmodule

// File: rtl/hex_rotation_decoder.sv
// Snapshots HEX0..HEX7, decodes one digit per clock, then tests one ring rotation
// per clock; reports the lowest matching rotation 17 cycles after start.
module hex_rotation_decoder
  import hex_glyph_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       start,
  input  logic [0:6] HEX0,
  input  logic [0:6] HEX1,
  input  logic [0:6] HEX2,
  input  logic [0:6] HEX3,
  input  logic [0:6] HEX4,
  input  logic [0:6] HEX5,
  input  logic [0:6] HEX6,
  input  logic [0:6] HEX7,
  output logic [2:0] M,
  output logic       match,
  output logic       bad_glyph,
  output logic       busy,
  output logic       done
);

  state_t          state, state_nxt;
  logic [2:0]      cnt;
  logic [7:0][6:0] hexv, snap;
  glyph_t          code [8];
  logic            bad, found;
  logic [2:0]      rlat;
  logic [2:0]      dec_code;
  logic [7:0]      eq;
  logic            hit, found_fin;

  // Buses are indexed by segment letter; repack so bit i is segment a+i.
  for (genvar b = 0; b < 7; b++) begin : g_repack
    assign hexv[0][b] = HEX0[b];
    assign hexv[1][b] = HEX1[b];
    assign hexv[2][b] = HEX2[b];
    assign hexv[3][b] = HEX3[b];
    assign hexv[4][b] = HEX4[b];
    assign hexv[5][b] = HEX5[b];
    assign hexv[6][b] = HEX6[b];
    assign hexv[7][b] = HEX7[b];
  end

  glyph_decode u_dec (
    .seg  (snap[cnt]),
    .code (dec_code)
  );

  // In MATCH, cnt is the rotation under test; the 3-bit subtract is the mod-8 wrap.
  for (genvar k = 0; k < 8; k++) begin : g_cmp
    assign eq[k] = (code[k] == W[3'(k) - cnt]);
  end
  assign hit       = &eq;
  assign found_fin = found | hit;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)       state_nxt = SCAN;
      SCAN:    if (cnt == 3'd7) state_nxt = MATCH;
      MATCH:   if (cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      snap      <= '0;
      bad       <= 1'b0;
      found     <= 1'b0;
      rlat      <= '0;
      M         <= '0;
      match     <= 1'b0;
      bad_glyph <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int k = 0; k < 8; k++) code[k] <= BLANK;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          snap  <= hexv;
          cnt   <= '0;
          bad   <= 1'b0;
          found <= 1'b0;
          rlat  <= '0;
        end
        SCAN: begin
          code[cnt] <= glyph_t'(dec_code);
          if (dec_code == BAD) bad <= 1'b1;
          cnt <= cnt + 3'd1;
        end
        MATCH: begin
          if (hit && !found) begin
            found <= 1'b1;
            rlat  <= cnt;
          end
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            done      <= 1'b1;
            bad_glyph <= bad;
            match     <= found_fin & ~bad;
            M         <= (found_fin & ~bad) ? (found ? rlat : cnt) : 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hex_rotation_decoder.md
# hex_rotation_decoder

Receive-side counterpart of the rotating "HELLO" display driver. The block snapshots the eight active-low seven-segment buses HEX0..HEX7 and decodes each pattern back to a glyph code. It then searches the eight ring rotations of the message and reports which rotation index (0-7) is on display. It sits beside the display driver as a self-check and loop-back monitor, and scans one digit or one rotation per clock.

## Interface
Parameters:
- none. Glyph encodings and message ring are fixed constants in the shared package.

Ports:
- CLOCK_50  in  1  system clock. Single clock domain.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  request a decode. Sampled only in IDLE.
- HEX0..HEX7  in  [0:6] each  segment patterns. Active-low; bit 0 = segment a … bit 6 = segment g.
- M  out  3  recovered rotation index. Valid when done=1.
- match  out  1  snapshot equals exactly one rotation of the message.
- bad_glyph  out  1  at least one digit was not H/E/L/O/blank.
- busy  out  1  decode in progress (not IDLE).
- done  out  1  one-cycle pulse; M/match/bad_glyph updated this cycle.

## Operation
- Glyph codes (3 bits):
  - BLANK=0 (1111111)
  - H=1 (0001001)
  - E=2 (0000110)
  - L=3 (1000111)
  - O=4 (1000000)
  - any other pattern = BAD=7
- Message ring W[0..7] = O,L,L,E,H,BLANK,BLANK,BLANK.
- Rotation r places W[(k−r) mod 8] on HEXk. Mod-8 is a natural 3-bit wrap; no explicit modulo logic.
- FSM states:
  - IDLE: start=1 loads all eight HEX buses into snapshot registers and goes to SCAN. start=0 stays in IDLE.
  - SCAN: a 3-bit digit counter i runs 0..7. Each cycle, decode snapshot[i] into code[i]. BAD sets a sticky bad flag. At i=7, go to MATCH with the counter cleared.
  - MATCH: the same counter is used as r, 0..7. Each cycle, compare code[k] with W[(k−r) mod 8] for all k in parallel. On the first hit, latch r and set the found flag; later hits are ignored, so the lowest r wins. At r=7, register the outputs and go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Output rules, registered on the MATCH→DONE edge:
  - bad_glyph = bad flag.
  - match = found AND NOT bad.
  - M = latched r if match, else 0.
- M, match and bad_glyph hold their values until the next DONE or Reset.
- The HEX inputs may change freely after the snapshot; only the snapshot is decoded.
- start is ignored in SCAN, MATCH and DONE. No queuing.
- Reset at any point, including mid-SCAN or mid-MATCH:
  - next state is IDLE;
  - M=0, match=0, bad_glyph=0, busy=0, done=0;
  - counter, flags and codes are cleared;
  - the partial result is discarded.

## Timing
- Cycle 0: start=1 in IDLE. The snapshot is loaded at the end of cycle 0.
- Cycles 1-8: SCAN. busy=1.
- Cycles 9-16: MATCH.
- Cycle 17: DONE. done=1, busy=1, and new outputs are visible.
- Fixed latency: start to done = 17 cycles.
- Cycle 18: IDLE. The earliest next accepted start is in cycle 18.
- busy is 1 in cycles 1-17 and 0 in IDLE.
- All outputs are registered; there is no combinational path from the inputs to the outputs.

## Structure
- Package hex_glyph_pkg holds:
  - glyph code constants BLANK/H/E/L/O/BAD;
  - the five 7-bit segment constants;
  - the ring array W;
  - the FSM state encoding IDLE/SCAN/MATCH/DONE.
- Sub-module glyph_decode: combinational, 7-bit pattern in, 3-bit code out, BAD by default. It is instantiated once and driven by snapshot[i].
- Top level contains the FSM, the shared 3-bit counter, the snapshot/code registers, the eight parallel comparators and the output registers.

## Test plan
- Sweep r = 0..7 with HEXk = seg(W[(k−r) mod 8]) and pulse start: done arrives exactly 17 cycles later with M=r, match=1, bad_glyph=0.
- r=3 pattern with HEX2 replaced by 0000000 → M=0, match=0, bad_glyph=1.
- All eight digits 1111111 → match=0, bad_glyph=0, M=0.
- Valid glyphs in a non-rotation order (H on HEX0, O on HEX4, rest as r=0) → match=0, bad_glyph=0.
- Apply r=5, then change HEX0..7 to r=2 in cycle 3 and pulse start in cycles 5 and 17 → a single done at cycle 17 with M=5. The start pulses at 5 and 17 are both ignored; no second done follows.
- Assert Reset in cycle 10 of a decode → cycle 11 shows IDLE with all outputs 0. A fresh start with r=6 yields M=6 after 17 cycles.
